keypad_entry_buffer: RTL
========================

// Module: keypad_entry_buffer
// PURPOSE
//   Consumes the debounced keypad stream (debouncedKey/debouncedValid) and builds a
//   6-digit decimal entry, shifted in from the right like a calculator display.
//   Drives the six SevenSegment digit values and per-digit enables.
//   Hands a committed BCD value plus a one-cycle strobe to downstream logic.
//   Sits between Debounce and the SevenSegment instances in the top level.
// PARAMETERS
//   KeyBackspace  4'hE  key code that deletes the most recent digit (* key)
//   KeyClear      4'hF  key code that clears the entry (# key)
//   KeyEnter      4'hD  key code that commits the entry (D key)
// PORTS
//   CLOCK_50        in   1   system clock, 50 MHz
//   Reset           in   1   asynchronous, active-low reset
//   debouncedKey    in   4   debounced key code, 0x0-0xF
//   debouncedValid  in   1   high while a debounced key is held
//   Digits          out  24  {Digit5..Digit0}, BCD, Digit0 = least significant / rightmost
//   DigitOn         out  6   bit i = 1: digit i holds an entered digit (display it)
//   EnteredValue    out  24  BCD value latched at last commit
//   EnteredStrobe   out  1   one-cycle pulse on commit
//   Overflow        out  1   sticky: a digit was pressed while full
//   Full            out  1   state == FULL
// BEHAVIOUR
//   Reset (async, Reset=0): Digits=0, DigitOn=0, EnteredValue=0, EnteredStrobe=0,
//     Overflow=0, LastValid=0, state=EMPTY. Takes effect mid-operation; no strobe is issued.
//   Keystroke event: debouncedValid=1 sampled while LastValid=0.
//     - LastValid <= debouncedValid every cycle.
//     - debouncedKey is sampled on the same edge; all updates are visible after that edge.
//     - Holding debouncedValid high yields exactly one event; the next event requires a low cycle.
//   Key classes: 0x0-0x9 = digit; KeyBackspace, KeyClear, KeyEnter = commands;
//     all other codes (A, B, C by default) are ignored with no state change.
//   Count n = number of entered digits, 0..6. DigitOn = (1<<n)-1, except as noted under DONE.
//   Shift-in: Digits <= {Digits[19:0], key}. Backspace: Digits <= {4'h0, Digits[23:4]}.
//   EnteredStrobe is 0 except in the cycle after a commit edge.
//   States and transitions:
//     EMPTY (n=0):
//       - digit 1-9: shift in, n=1, go to ENTRY.
//       - digit 0: ignored (no leading zeros).
//       - backspace, clear: no-op.
//       - enter: commit 0, DigitOn=6'b000001, go to DONE.
//     ENTRY (n=1..5):
//       - digit: shift in, n+1; if n reaches 6, go to FULL.
//       - backspace: shift out, n-1; if n reaches 0, go to EMPTY.
//       - clear: Digits=0, n=0, go to EMPTY.
//       - enter: commit, go to DONE.
//     FULL (n=6):
//       - digit: Digits unchanged, Overflow<=1.
//       - backspace: n=5, go to ENTRY.
//       - clear: go to EMPTY.
//       - enter: commit, go to DONE.
//     DONE (Digits and DigitOn held):
//       - digit 1-9: Digits={20'h0,key}, n=1, go to ENTRY.
//       - digit 0: Digits=0, n=0, go to EMPTY.
//       - clear: go to EMPTY.
//       - backspace: no-op.
//       - enter: re-commit the same value.
//   Commit: EnteredValue<=Digits; EnteredStrobe=1 for exactly one cycle.
//   Overflow clears on any backspace, clear or enter event; it is unaffected by ignored keys.
// TESTING
//   1. Reset, then keys 1,2,3 -> Digits=24'h000123, DigitOn=6'b000111, state ENTRY.
//   2. Keys 0,0,7 from EMPTY -> first two 0s ignored; Digits=24'h000007, DigitOn=6'b000001.
//   3. Keys 1..7 -> Digits=24'h123456, Full=1, Overflow=1; then backspace -> 24'h012345,
//      DigitOn=6'b011111, Overflow=0.
//   4. Keys 4,2,D -> EnteredValue=24'h000042, EnteredStrobe high exactly 1 cycle;
//      then key 9 -> Digits=24'h000009.
//   5. Hold debouncedValid=1 with key 5 for 1000 cycles -> a single '5' is entered;
//      key A and key C -> no change.
//   6. Assert Reset mid-entry while an enter event is pending -> all outputs 0, no strobe,
//      state EMPTY.

Source files
------------

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer: builds a 6-digit BCD entry from the debounced keypad stream,
// shifted in from the right, and commits it with a one-cycle strobe.
//   CLOCK_50       - system clock
//   Reset          - asynchronous active-low reset
//   debouncedKey   - debounced key code
//   debouncedValid - high while a debounced key is held
//   Digits         - {Digit5..Digit0} BCD, Digit0 rightmost
//   DigitOn        - per-digit display enables
//   EnteredValue   - BCD value latched at last commit
//   EnteredStrobe  - one-cycle pulse on commit
//   Overflow       - sticky: digit pressed while full
//   Full           - six digits entered
module keypad_entry_buffer #(
  parameter logic [3:0] KeyBackspace = 4'hE,
  parameter logic [3:0] KeyClear     = 4'hF,
  parameter logic [3:0] KeyEnter     = 4'hD
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [3:0]  debouncedKey,
  input  logic        debouncedValid,
  output logic [23:0] Digits,
  output logic [5:0]  DigitOn,
  output logic [23:0] EnteredValue,
  output logic        EnteredStrobe,
  output logic        Overflow,
  output logic        Full
);

  typedef enum logic [1:0] {EMPTY, ENTRY, FULL, DONE} state_t;

  state_t      state_q, state_d;
  logic [23:0] digits_q, digits_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  on_q, on_d;
  logic [23:0] entered_q, entered_d;
  logic        strobe_q, strobe_d;
  logic        ovf_q, ovf_d;
  logic        last_valid_q, last_valid_d;

  logic ev, is_digit, is_bs, is_clr, is_ent, commit;

  function automatic logic [5:0] on_mask(input logic [2:0] n);
    logic [6:0] m;
    m = (7'd1 << n) - 7'd1;
    return m[5:0];
  endfunction

  always_comb begin
    ev       = debouncedValid && !last_valid_q;
    is_digit = (debouncedKey <= 4'd9);
    is_bs    = (debouncedKey == KeyBackspace);
    is_clr   = (debouncedKey == KeyClear);
    is_ent   = (debouncedKey == KeyEnter);

    state_d      = state_q;
    digits_d     = digits_q;
    cnt_d        = cnt_q;
    on_d         = on_q;
    entered_d    = entered_q;
    strobe_d     = 1'b0;
    ovf_d        = ovf_q;
    last_valid_d = debouncedValid;
    commit       = 1'b0;

    if (ev) begin
      if (is_bs || is_clr || is_ent) ovf_d = 1'b0;
      case (state_q)
        EMPTY: begin
          if (is_digit && debouncedKey != 4'd0) begin
            digits_d = {digits_q[19:0], debouncedKey};
            cnt_d    = 3'd1;
            state_d  = ENTRY;
          end else if (is_ent) begin
            commit  = 1'b1;
            on_d    = 6'b000001;
            state_d = DONE;
          end
        end
        ENTRY: begin
          if (is_digit) begin
            digits_d = {digits_q[19:0], debouncedKey};
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd5) state_d = FULL;
          end else if (is_bs) begin
            digits_d = {4'h0, digits_q[23:4]};
            cnt_d    = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = EMPTY;
          end else if (is_clr) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = EMPTY;
          end else if (is_ent) begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
        FULL: begin
          if (is_digit) begin
            ovf_d = 1'b1;
          end else if (is_bs) begin
            digits_d = {4'h0, digits_q[23:4]};
            cnt_d    = 3'd5;
            state_d  = ENTRY;
          end else if (is_clr) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = EMPTY;
          end else if (is_ent) begin
            commit  = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (is_digit) begin
            digits_d = {20'h0, debouncedKey};
            if (debouncedKey != 4'd0) begin
              cnt_d   = 3'd1;
              state_d = ENTRY;
            end else begin
              cnt_d   = '0;
              state_d = EMPTY;
            end
          end else if (is_clr) begin
            digits_d = '0;
            cnt_d    = '0;
            state_d  = EMPTY;
          end else if (is_ent) begin
            commit = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
      // DONE holds the enables it was entered with; elsewhere they follow the count
      if (state_d != DONE) on_d = on_mask(cnt_d);
    end

    if (commit) begin
      entered_d = digits_q;
      strobe_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Reset) begin
    if (!Reset) begin
      state_q      <= EMPTY;
      digits_q     <= '0;
      cnt_q        <= '0;
      on_q         <= '0;
      entered_q    <= '0;
      strobe_q     <= 1'b0;
      ovf_q        <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digits_q     <= digits_d;
      cnt_q        <= cnt_d;
      on_q         <= on_d;
      entered_q    <= entered_d;
      strobe_q     <= strobe_d;
      ovf_q        <= ovf_d;
      last_valid_q <= last_valid_d;
    end
  end

  assign Digits        = digits_q;
  assign DigitOn       = on_q;
  assign EnteredValue  = entered_q;
  assign EnteredStrobe = strobe_q;
  assign Overflow      = ovf_q;
  assign Full          = (state_q == FULL);

endmodule
